mux8to1: RTL and testbench
==========================

MUX8TO1 -- requirements
Module: mux8to1

Interface
REQ-001 Parameter: OUT_RST, default 8'h00, value loaded into Out on reset.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: Sel  input  3  select index, 0..7, chooses one bit of I.
REQ-005 Port: I  input  8  data inputs; I[k] is channel k.
REQ-006 Port: SW  input  1  output enable switch; 1 = pass selected channel, 0 = blank output.
REQ-007 Port: Out  output  8  registered output; bit position k mirrors channel k when selected.
REQ-008 The block SHALL have exactly one clock (clk) and one reset (rst), synchronous and active-high.

Function
REQ-009 Out SHALL be driven directly from a register clocked by clk, with no combinational path from inputs to Out.
REQ-010 On each rising clk edge with rst=0 and SW=1, the block SHALL load Out[Sel] with I[Sel] and every other Out bit with 0.
REQ-011 On each rising clk edge with rst=0 and SW=0, the block SHALL load Out with 8'h00, regardless of Sel and I.
REQ-012 Latency SHALL be exactly one clk cycle from a change on Sel, I or SW to the corresponding Out value.
REQ-013 All 8 Sel values SHALL be legal; no illegal or undefined select codes exist.
REQ-014 A Sel change and an I change in the same cycle SHALL both be reflected in the next Out value.
REQ-015 Out SHALL hold its value between clk edges; input glitches between edges SHALL have no effect.
REQ-016 Inputs X/Z SHALL NOT be masked; the block SHALL introduce no storage other than the Out register.

Reset
REQ-017 When rst=1 at a rising clk edge, Out SHALL load OUT_RST (default 8'h00).
REQ-018 rst SHALL take priority over SW, Sel and I in the same cycle.
REQ-019 Reset asserted mid-operation SHALL take effect on the next edge.
REQ-020 The first edge after rst deasserts SHALL resume normal operation per REQ-010/011.

Configuration
REQ-021 Macro MUX8TO1_BCAST_EN, when defined, SHALL change the SW=1 behaviour to broadcast: Out <= {8{I[Sel]}}.
REQ-022 Without MUX8TO1_BCAST_EN, the positional behaviour of REQ-010 SHALL apply.
REQ-023 SW=0, reset and latency behaviour SHALL be identical with and without the macro.

Verification
REQ-024 rst=1 for 2 edges with any inputs -> Out=8'h00; then rst=0, SW=0, I=8'h33, Sel=0 -> Out=8'h00.
REQ-025 I=8'h33, SW=1, Sel stepped 0..7 one per cycle -> Out one cycle later = 01,02,00,00,10,20,00,00.
REQ-026 SW=1, Sel=4, I=8'h33, then SW=0 -> Out=8'h10 then 8'h00 the following cycle.
REQ-027 SW=1, Sel=5, I toggled 8'h33->8'h00 in the same cycle Sel changes to 1 -> Out=8'h00 next cycle.
REQ-028 rst=1 asserted while Out=8'h20 -> Out=8'h00 on that edge despite SW=1.
REQ-029 With MUX8TO1_BCAST_EN defined: I=8'h33, SW=1, Sel=1 -> Out=8'hFF; Sel=2 -> Out=8'h00.

Source files
------------

// File: rtl/mux8to1_if.sv
// Bundles the select, data, enable and output signals of mux8to1.
// Latency: none. This file only carries the signals.
// Backpressure: none. The mux accepts new inputs on every clock.
//
// Signals:
//   Sel [2:0] select index. It chooses channel I[Sel].
//   I   [7:0] data channels. I[k] is channel k.
//   SW        output enable. 1 passes the selected channel, 0 blanks the output.
//   Out [7:0] registered output of the mux.
// Modports:
//   master drives Sel, I and SW, and observes Out.
//   slave is the mux itself.
interface mux8to1_if;
    logic [2:0] Sel;
    logic [7:0] I;
    logic       SW;
    logic [7:0] Out;

    modport master (
        output Sel,
        output I,
        output SW,
        input  Out
    );

    modport slave (
        input  Sel,
        input  I,
        input  SW,
        output Out
    );
endinterface

// File: rtl/mux8to1.sv
// Registered 8:1 bit selector. The chosen bit I[Sel] lands in Out at the same bit position.
// Latency: 1 clk from Sel, I or SW to Out. There is no combinational path from input to output.
// Backpressure: none. Inputs are sampled on every rising clk edge.
//
// Ports:
//   clk : single clock. All state updates on its rising edge.
//   rst : synchronous, active-high reset. Out loads OUT_RST.
//   bus : mux8to1_if.slave (Sel, I, SW in; Out out).
// Parameter:
//   OUT_RST : value loaded into Out on reset. The default is 8'h00.
// Build option:
//   MUX8TO1_BCAST_EN : when defined and SW=1, the selected bit is copied to all 8 Out bits.
//                      It does not change SW=0, reset or latency behaviour.
module mux8to1 #(
    parameter logic [7:0] OUT_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    mux8to1_if.slave   bus
);

    logic [7:0] out_q;
    logic [7:0] out_d;

    // Next-state value. I[Sel] is passed through unmasked, so an X or Z on the
    // selected input stays visible at Out.
    always_comb begin
        out_d = 8'h00;
        if (bus.SW) begin
`ifdef MUX8TO1_BCAST_EN
            out_d = {8{bus.I[bus.Sel]}};
`else
            out_d[bus.Sel] = bus.I[bus.Sel];
`endif
        end
    end

    // Out is the only storage in the block. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.Out = out_q;

endmodule

// File: tb/tb_mux8to1.sv
// Directed, table-driven bench for mux8to1.
// Each table row is one clock edge: inputs are driven at the falling edge and Out is checked 1 time unit after the rising edge.
// A second instance with a non-zero OUT_RST runs on the same stimulus so that the reset value is checked as well.
module tb_mux8to1;

`ifdef MUX8TO1_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mux8to1_if bus ();
    mux8to1_if bus2 ();

    assign bus2.Sel = bus.Sel;
    assign bus2.I   = bus.I;
    assign bus2.SW  = bus.SW;

    mux8to1 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux8to1 #(.OUT_RST(8'hA5)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       sw;
        logic [2:0] sel;
        logic [7:0] i;
        logic [7:0] exp_pos;   // expected Out in the default (positional) build
        logic [7:0] exp_bc;    // expected Out in the broadcast build
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sw, input logic [2:0] sel, input logic [7:0] i);
        @(negedge clk);
        rst     = r;
        bus.SW  = sw;
        bus.Sel = sel;
        bus.I   = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp;
        logic [7:0] held;

        // Reset for 2 edges with arbitrary inputs, then SW=0.
        vecs[0]  = '{1'b1, 1'b1, 3'd3, 8'hFF, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 3'd7, 8'hAA, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 8'h33, 8'h00, 8'h00};
        // Sel stepped 0..7 with I=33.
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 8'h33, 8'h01, 8'hFF};
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 8'h33, 8'h02, 8'hFF};
        vecs[5]  = '{1'b0, 1'b1, 3'd2, 8'h33, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 3'd3, 8'h33, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 8'h33, 8'h10, 8'hFF};
        vecs[8]  = '{1'b0, 1'b1, 3'd5, 8'h33, 8'h20, 8'hFF};
        vecs[9]  = '{1'b0, 1'b1, 3'd6, 8'h33, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 3'd7, 8'h33, 8'h00, 8'h00};
        // Sel=4 output, then blanked by SW=0.
        vecs[11] = '{1'b0, 1'b1, 3'd4, 8'h33, 8'h10, 8'hFF};
        vecs[12] = '{1'b0, 1'b0, 3'd4, 8'h33, 8'h00, 8'h00};
        // Sel and I change together.
        vecs[13] = '{1'b0, 1'b1, 3'd5, 8'h33, 8'h20, 8'hFF};
        vecs[14] = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h00, 8'h00};
        // Reset while Out=20 with SW=1, then resume.
        vecs[15] = '{1'b0, 1'b1, 3'd5, 8'h33, 8'h20, 8'hFF};
        vecs[16] = '{1'b1, 1'b1, 3'd5, 8'h33, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 3'd7, 8'hFF, 8'h80, 8'hFF};
        vecs[18] = '{1'b0, 1'b1, 3'd6, 8'h40, 8'h40, 8'hFF};

        rst     = 1'b1;
        bus.SW  = 1'b0;
        bus.Sel = 3'd0;
        bus.I   = 8'h00;

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].rst, vecs[v].sw, vecs[v].sel, vecs[v].i);
            exp = BCAST ? vecs[v].exp_bc : vecs[v].exp_pos;
            check($sformatf("vec%0d_out", v), bus.Out, exp);
            check($sformatf("vec%0d_out2", v), bus2.Out, vecs[v].rst ? 8'hA5 : exp);
        end

        // Inputs that change between edges must not reach Out until the next edge.
        drive(1'b0, 1'b1, 3'd2, 8'h04);
        held = BCAST ? 8'hFF : 8'h04;
        check("glitch_pre", bus.Out, held);
        #1  bus.Sel = 3'd0; bus.I = 8'h01; bus.SW = 1'b0;
        #1  bus.SW = 1'b1;
        #1  bus.I  = 8'hFE;
        #1  check("glitch_hold", bus.Out, held);
        // The last values before the edge are the ones that are sampled.
        @(posedge clk);
        #1;
        check("glitch_after", bus.Out, 8'h00);

        // Latency: a change at the falling edge must not appear before the next rising edge.
        drive(1'b0, 1'b1, 3'd3, 8'h08);
        held = BCAST ? 8'hFF : 8'h08;
        check("lat_a", bus.Out, held);
        @(negedge clk);
        bus.Sel = 3'd6;
        bus.I   = 8'h40;
        #1 check("lat_not_early", bus.Out, held);
        @(posedge clk);
        #1 check("lat_one_cycle", bus.Out, BCAST ? 8'hFF : 8'h40);

`ifdef MUX8TO1_BCAST_EN
        drive(1'b0, 1'b1, 3'd1, 8'h33);
        check("bcast_sel1", bus.Out, 8'hFF);
        drive(1'b0, 1'b1, 3'd2, 8'h33);
        check("bcast_sel2", bus.Out, 8'h00);
        drive(1'b0, 1'b0, 3'd1, 8'h33);
        check("bcast_sw0", bus.Out, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
